// File: rtl/cpu_multicycle.sv
// Multi-cycle accumulator CPU over a single-port synchronous RAM: C/Z flags, output register,
// halt. Define CPU_STACK_EN to add CALL/RET with an internal return-address stack.
module cpu_multicycle #(
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned MEM_DATA_WIDTH = 8,
    parameter int unsigned STACK_DEPTH    = 4
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [MEM_DATA_WIDTH-1:0] mem_data_out,
    output logic [MEM_DATA_WIDTH-1:0] mem_data_in,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address,
    output logic                      write_ena,
    output logic [MEM_DATA_WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      carry_flag,
    output logic                      zero_flag,
    output logic                      halted,
    output logic                      stack_fault
);
    typedef enum logic [2:0] {
        StFetch, StDecode, StOper, StOplatch, StMem, StMemexec, StHalt
    } state_e;

    typedef enum logic [3:0] {
        OpNop, OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp, OpJc,
        OpJz, OpAnd, OpOr, OpXor, OpCall, OpRet, OpOut, OpHlt
    } op_e;

    state_e                    state_q, state_d;
    op_e                       ir_q, ir_d, dec_op;
    logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d, or_q, or_d, opnd, pc_inc;
    logic [MEM_DATA_WIDTH-1:0] a_q, a_d, out_q, out_d, logic_res;
    logic                      c_q, c_d, z_q, z_d, out_valid_q, out_valid_d;
    logic [MEM_DATA_WIDTH:0]   sum, diff;

    // Only the opcode nibble is kept; low bits of the opcode word are don't-care.
    assign dec_op = op_e'(mem_data_out[MEM_DATA_WIDTH-1 -: 4]);
    assign opnd   = MEM_ADDR_WIDTH'(mem_data_out);
    assign pc_inc = pc_q + MEM_ADDR_WIDTH'(1);
    assign sum    = {1'b0, a_q} + {1'b0, mem_data_out};
    assign diff   = {1'b0, a_q} + {1'b0, ~mem_data_out} + (MEM_DATA_WIDTH + 1)'(1);

    always_comb begin
        case (ir_q)
            OpAnd:   logic_res = a_q & mem_data_out;
            OpOr:    logic_res = a_q | mem_data_out;
            default: logic_res = a_q ^ mem_data_out;
        endcase
    end

`ifdef CPU_STACK_EN
    localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

    logic [MEM_ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] stack_d [STACK_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] stack_top;
    logic [SpW-1:0]            sp_q, sp_d;
    logic                      fault_q, fault_d, stack_full, stack_empty;

    assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign stack_fault = fault_q;

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
            if (sp_q == SpW'(i + 1)) stack_top = stack_q[i];
        end
    end
`else
    assign stack_fault = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        ir_d        = ir_q;
        or_d        = or_q;
        c_d         = c_q;
        z_d         = z_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
`ifdef CPU_STACK_EN
        sp_d        = sp_q;
        stack_d     = stack_q;
        fault_d     = fault_q;
`endif
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                ir_d    = dec_op;
                pc_d    = pc_inc;
                state_d = StFetch;
                case (dec_op)
                    OpLda, OpAdd, OpSub, OpSta, OpLdi, OpJmp, OpJc, OpJz,
                    OpAnd, OpOr, OpXor: state_d = StOper;
                    OpOut: begin
                        out_d       = a_q;
                        out_valid_d = 1'b1;
                    end
                    OpHlt: state_d = StHalt;
`ifdef CPU_STACK_EN
                    OpCall: state_d = StOper;
                    OpRet: begin
                        if (stack_empty) begin
                            fault_d = 1'b1;
                            pc_d    = pc_q;
                            state_d = StHalt;
                        end else begin
                            pc_d = stack_top;
                            sp_d = sp_q - SpW'(1);
                        end
                    end
`endif
                    default: ;
                endcase
            end
            StOper: state_d = StOplatch;
            StOplatch: begin
                or_d    = opnd;
                pc_d    = pc_inc;
                state_d = StFetch;
                case (ir_q)
                    OpLdi: begin
                        a_d = mem_data_out;
                        z_d = (mem_data_out == '0);
                    end
                    OpJmp: pc_d = opnd;
                    OpJc:  if (c_q) pc_d = opnd;
                    OpJz:  if (z_q) pc_d = opnd;
`ifdef CPU_STACK_EN
                    OpCall: begin
                        if (stack_full) begin
                            fault_d = 1'b1;
                            pc_d    = pc_q;
                            state_d = StHalt;
                        end else begin
                            // Return address is the word after the operand.
                            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                                if (sp_q == SpW'(i)) stack_d[i] = pc_inc;
                            end
                            sp_d = sp_q + SpW'(1);
                            pc_d = opnd;
                        end
                    end
`endif
                    default: state_d = StMem;
                endcase
            end
            StMem: state_d = (ir_q == OpSta) ? StFetch : StMemexec;
            StMemexec: begin
                state_d = StFetch;
                case (ir_q)
                    OpLda: begin
                        a_d = mem_data_out;
                        z_d = (mem_data_out == '0);
                    end
                    OpAdd: begin
                        {c_d, a_d} = sum;
                        z_d        = (sum[MEM_DATA_WIDTH-1:0] == '0);
                    end
                    OpSub: begin
                        {c_d, a_d} = diff;
                        z_d        = (diff[MEM_DATA_WIDTH-1:0] == '0);
                    end
                    OpAnd, OpOr, OpXor: begin
                        a_d = logic_res;
                        c_d = 1'b0;
                        z_d = (logic_res == '0);
                    end
                    default: ;
                endcase
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            a_q         <= '0;
            ir_q        <= OpNop;
            or_q        <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef CPU_STACK_EN
            sp_q        <= '0;
            stack_q     <= '{default: '0};
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            ir_q        <= ir_d;
            or_q        <= or_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef CPU_STACK_EN
            sp_q        <= sp_d;
            stack_q     <= stack_d;
            fault_q     <= fault_d;
`endif
        end
    end

    // Memory side is driven from registered state only, never from mem_data_out.
    assign mem_address = (state_q == StMem || state_q == StMemexec) ? or_q : pc_q;
    assign write_ena   = (state_q == StMem) && (ir_q == OpSta) && !rst;
    assign mem_data_in = a_q;
    assign out_data    = out_q;
    assign out_valid   = out_valid_q;
    assign carry_flag  = c_q;
    assign zero_flag   = z_q;
    assign halted      = (state_q == StHalt);

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised multi-cycle accumulator CPU for the 8-bit computer. Successor to the fixed 8-bit cpu shell.
- Runs fetch/decode/execute against the single-port synchronous RAM through the same memory interface.
- Adds the following over the shell:
  - carry and zero flags, used by conditional jumps
  - an output register with a valid strobe
  - halt
  - optional call/return stack

Parameters:
- MEM_ADDR_WIDTH, 8: address width. PC and operand-address width.
- MEM_DATA_WIDTH, 8: data/accumulator width. Must be ≥5. Opcode is bits [W-1:W-4].
- STACK_DEPTH, 4: return-address entries. Used only with CPU_STACK_EN.

Ports:
- clock  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_data_out  in  MEM_DATA_WIDTH  RAM read data, valid the cycle after mem_address is presented
- mem_data_in  out  MEM_DATA_WIDTH  RAM write data (accumulator)
- mem_address  out  MEM_ADDR_WIDTH  RAM address
- write_ena  out  1  RAM write strobe, one cycle
- out_data  out  MEM_DATA_WIDTH  output register
- out_valid  out  1  one-cycle pulse when out_data is updated
- carry_flag  out  1  C flag
- zero_flag  out  1  Z flag
- halted  out  1  core stopped
- stack_fault  out  1  stack over/underflow, sticky until rst

Behaviour:
- Reset (rst high at an edge):
  - PC, A, IR, OR, flags, out_data, stack pointer: 0.
  - out_valid, halted, stack_fault: 0. State: FETCH.
  - write_ena is gated by ~rst, so it is 0 in any cycle rst is high, including mid-STA.
- Memory outputs:
  - mem_address, write_ena and mem_data_in are decoded from registered state only, never from mem_data_out.
  - mem_data_in = A at all times. write_ena = 1 only in STA's MEM cycle.
- State sequence:
  - FETCH: mem_address = PC.
  - DECODE: IR ← mem_data_out; PC ← PC+1. One-word ops execute here.
  - OPER: mem_address = PC.
  - OPLATCH: OR ← mem_data_out[MEM_ADDR_WIDTH-1:0], zero-extended if the address is wider; PC ← PC+1. Immediate and jump ops execute here.
  - MEM: mem_address = OR. STA writes here.
  - MEMEXEC: reads complete here.
  - HALT: absorbing until rst.
- Opcodes (upper nibble); low bits of the opcode word are ignored:
  - 0 NOP.
  - 1 LDA a: A ← M[a]. Z updated, C kept.
  - 2 ADD a: {C,A} ← A+M[a]. Z updated.
  - 3 SUB a: {C,A} ← A+~M[a]+1. C=1 means no borrow. Z updated.
  - 4 STA a: M[a] ← A.
  - 5 LDI i: A ← i. Z updated, C kept.
  - 6 JMP a.
  - 7 JC a: jump if C.
  - 8 JZ a: jump if Z.
  - 9 AND a, A OR a, B XOR a: Z updated, C ← 0.
  - C/D: see Optional Feature.
  - E OUT: out_data ← A; out_valid = 1 for the next cycle only.
  - F HLT: halted = 1.
- Cycle counts, FETCH to the next FETCH:
  - NOP/OUT: 2.
  - HLT: 2 to reach HALT.
  - LDI/JMP/JC/JZ: 4, whether the jump is taken or not.
  - STA: 5.
  - LDA/ADD/SUB/AND/OR/XOR: 6.
- Boundaries:
  - PC wraps from 2^MEM_ADDR_WIDTH−1 to 0, including between the opcode word and its operand word.
  - Arithmetic is modulo 2^MEM_DATA_WIDTH. Carry is bit MEM_DATA_WIDTH of the sum.
  - Flags are registered, so a JC/JZ immediately after ADD/SUB sees the new flags.
  - In HALT: write_ena = 0, mem_address = PC; no state changes except by rst.

Optional Feature:
- Macro: CPU_STACK_EN.
- Enabled:
  - C CALL a: push the return PC (address after the operand word), then PC ← a. 4 cycles.
  - D RET: pop into PC. 2 cycles.
  - Internal register stack of STACK_DEPTH entries.
  - CALL with the stack full, or RET with the stack empty: stack_fault ← 1, halted ← 1, PC and stack unchanged.
- Disabled:
  - C is fetched as a one-word NOP (2 cycles). Its operand word is then fetched as an instruction.
  - D is a NOP.
  - stack_fault is tied to 0. No stack storage is synthesised.
  - The port list is identical either way.

Test Plan:
- Add and output:
  - Stimulus: RAM 0x00: LDI 0x07; ADD [0x20]; OUT; HLT; with M[0x20]=0xFA.
  - Required: out_data=0x01, carry_flag=1, zero_flag=0, exactly one out_valid pulse, halted=1 after 14 cycles.
- Subtract and branch:
  - Stimulus: LDI 0x05; SUB [x] with M[x]=0x05; JZ 0x30.
  - Required: Z=1, C=1, the next FETCH address is 0x30.
  - Repeat with M[x]=0x06: Z=0, C=0, branch not taken.
- Store timing:
  - Stimulus: STA 0x40 with A=0x5A.
  - Required: write_ena high for exactly one cycle, with mem_address=0x40 and mem_data_in=0x5A; then read back via LDA 0x40.
- Wrap-around:
  - Stimulus: JMP 0xFF with a NOP at 0xFF.
  - Required: the next fetch is at 0x00. Also, a two-word op at 0xFF takes its operand from 0x00.
- Reset mid-operation:
  - Stimulus: assert rst in STA's MEM cycle.
  - Required: write_ena=0 that cycle, RAM unchanged, then PC=0 and all outputs at reset values.
- Stack (macro enabled, STACK_DEPTH=4):
  - Stimulus: 4 nested CALLs then 4 RETs.
  - Required: execution returns correctly.
  - Stimulus: a 5th nested CALL.
  - Required: stack_fault=1 and halted=1.
  - With the macro disabled, the same program treats C/D as NOPs and stack_fault stays 0.
